// File: rtl/icache_pkg.sv
// Shared widths, FSM state encoding and line-word selection for the direct-mapped I-cache.
package icache_pkg;

   localparam int unsigned WORD_SIZE   = 16;
   localparam int unsigned LINE_WORDS  = 4;
   localparam int unsigned LINE_BITS   = WORD_SIZE * LINE_WORDS;
   localparam int unsigned OFFSET_BITS = 2;
   localparam int unsigned INDEX_BITS  = 3;
   localparam int unsigned NUM_LINES   = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } state_e;

   function automatic logic [WORD_SIZE-1:0] line_word(input logic [LINE_BITS-1:0]   line,
                                                      input logic [OFFSET_BITS-1:0] offset);
      return line[offset*WORD_SIZE +: WORD_SIZE];
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: asynchronous lookup, synchronous line write, flash clear of valid bits.
module icache_line_store
   import icache_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [INDEX_BITS-1:0] rd_index_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [LINE_BITS-1:0]  rd_line_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_index_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [LINE_BITS-1:0]  wr_line_i,
   input  logic                  clear_i
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   always_comb begin
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = '0;
      end else if (wr_en_i) begin
         valid_d[wr_index_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tags and data need no reset: they are only trusted behind a valid bit.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_line_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 0-cycle hit path, single-line refill FSM,
// hit/miss counters and the blocking memory line-read handshake.
module icache_direct
   import icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 c_readC,
   input  logic [WORD_SIZE-1:0] c_address,
   output logic [WORD_SIZE-1:0] c_data,
   output logic                 c_readyC,
   input  logic                 flush,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [LINE_BITS-1:0] i_data,
   input  logic                 i_readyM,
   input  logic                 i_input_readyM,
   output logic [15:0]          hit_count,
   output logic [15:0]          miss_count
);

   localparam int unsigned LineAddrBits = WORD_SIZE - OFFSET_BITS;

   state_e                  state_q, state_d;
   logic [LineAddrBits-1:0] miss_line_q, miss_line_d;
   logic [15:0]             hit_cnt_q, hit_cnt_d;
   logic [15:0]             miss_cnt_q, miss_cnt_d;
   logic                    flush_pend_q, flush_pend_d;
   logic                    rdy_seen_q, rdy_seen_d;

   logic [INDEX_BITS-1:0]   req_index;
   logic [TAG_BITS-1:0]     req_tag;
   logic                    rd_valid;
   logic [TAG_BITS-1:0]     rd_tag;
   logic [LINE_BITS-1:0]    rd_line;
   logic                    lookup_hit;
   logic                    wr_en;
   logic                    clear;

   assign req_index  = c_address[OFFSET_BITS +: INDEX_BITS];
   assign req_tag    = c_address[WORD_SIZE-1 -: TAG_BITS];
   assign lookup_hit = rd_valid && (rd_tag == req_tag);

   icache_line_store u_line_store (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .rd_index_i (req_index),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_line_o  (rd_line),
      .wr_en_i    (wr_en),
      .wr_index_i (miss_line_q[INDEX_BITS-1:0]),
      .wr_tag_i   (miss_line_q[LineAddrBits-1 -: TAG_BITS]),
      .wr_line_i  (i_data),
      .clear_i    (clear)
   );

   always_comb begin
      state_d      = state_q;
      miss_line_d  = miss_line_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      flush_pend_d = flush_pend_q;
      rdy_seen_d   = rdy_seen_q;
      c_readyC     = 1'b0;
      c_data       = '0;
      i_readM      = 1'b0;
      i_address    = '0;
      wr_en        = 1'b0;
      clear        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (flush) begin
               clear = 1'b1;
            end else if (c_readC) begin
               if (lookup_hit) begin
                  c_readyC  = 1'b1;
                  c_data    = line_word(rd_line, c_address[OFFSET_BITS-1:0]);
                  hit_cnt_d = hit_cnt_q + 16'd1;
               end else begin
                  miss_line_d = c_address[WORD_SIZE-1:OFFSET_BITS];
                  miss_cnt_d  = miss_cnt_q + 16'd1;
                  // Memory still busy with an abandoned refill must go idle before we hand off.
                  rdy_seen_d  = i_readyM;
                  state_d     = StReq;
               end
            end
         end

         StReq: begin
            i_readM   = 1'b1;
            i_address = {miss_line_q, {OFFSET_BITS{1'b0}}};
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            if (i_readyM) begin
               rdy_seen_d = 1'b1;
            end else if (rdy_seen_q) begin
               state_d = StWait;
            end
         end

         StWait: begin
            i_address = {miss_line_q, {OFFSET_BITS{1'b0}}};
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            if (i_input_readyM) begin
               // A flush seen during the refill discards the incoming line as well.
               if (flush_pend_q || flush) begin
                  clear = 1'b1;
               end else begin
                  wr_en = 1'b1;
               end
               flush_pend_d = 1'b0;
               state_d      = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         miss_line_q  <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         rdy_seen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         miss_line_q  <= miss_line_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         flush_pend_q <= flush_pend_d;
         rdy_seen_q   <= rdy_seen_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the line-oriented instruction port of the main memory model.
- Serves 16-bit instruction words to the CPU with a 0-cycle hit path.
- On a miss, refills one 4-word (64-bit) line through the memory's blocking i_readM / i_readyM / i_input_readyM handshake.

Parameters:
- WORD_SIZE, 16, CPU word width and address width.
- LINE_WORDS, 4, words per line; fixed to match the memory line size; the offset field is 2 bits.
- INDEX_BITS, 3, log2 of the line count; the default gives 8 lines.
- TAG_BITS, WORD_SIZE-INDEX_BITS-2, tag width; 11 at the defaults.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- c_readC  in  1  CPU fetch request; held until c_readyC.
- c_address  in  16  CPU word address.
- c_data  out  16  instruction word; valid only while c_readyC=1.
- c_readyC  out  1  hit: c_data valid for the current c_address this cycle.
- flush  in  1  invalidate all lines.
- i_readM  out  1  line read request to memory.
- i_address  out  16  line base address {tag,index,2'b00}.
- i_data  in  64  refill line; word k is bits [16k+15:16k].
- i_readyM  in  1  memory idle, can accept a request.
- i_input_readyM  in  1  i_data valid this period.
- hit_count  out  16  hits since reset; wraps.
- miss_count  out  16  misses since reset; wraps.

Behaviour:
- Reset is asynchronous: on reset_n low, immediately do all of the following.
  - State goes to IDLE.
  - All valid bits clear; tags and data are don't-care.
  - i_readM=0, i_address=0.
  - Counters = 0; pending flush clears.
  - c_readyC=0 and c_data=0 while in reset.
- Address split: offset=c_address[1:0], index=c_address[2+INDEX_BITS-1:2], tag=upper TAG_BITS.
- IDLE:
  - c_readyC = c_readC & valid[index] & (tag_store[index]==tag), combinational, same cycle.
  - c_data = line[index] word[offset] when c_readyC=1, else 0.
  - Each posedge with c_readyC=1 increments hit_count.
  - On a posedge with c_readC=1 and a miss: latch miss_addr = c_address, miss_count++, go to REQ.
- REQ:
  - i_readM=1 and i_address={miss_addr[15:2],2'b00}; c_readyC=0.
  - Stay while i_readyM=1. The memory samples the request at negedge and drops i_readyM.
  - At the first posedge with i_readyM=0, go to WAIT and deassert i_readM.
- WAIT:
  - i_readM=0, c_readyC=0.
  - At the posedge with i_input_readyM=1: write i_data into line[miss index], tag = miss tag, valid=1, then go to IDLE.
  - The first possible hit on the refilled line is the following cycle.
- Miss penalty: about 6 cycles from miss detection to hit, set by memory latency (4-cycle count plus handshake edges).
- CPU changes c_address during REQ/WAIT: no effect. The refill completes for miss_addr and IDLE re-evaluates the new address.
- c_readC dropped during a refill: the refill still completes and the line is installed.
- Flush:
  - In IDLE: all valid bits clear at that posedge. c_readyC is forced 0 in the flush cycle and no miss is started.
  - In REQ/WAIT: set flush_pending. The refill completes, but the line is NOT marked valid. flush_pending and all valid bits clear on entry to IDLE.
- i_input_readyM while in IDLE or REQ (stale completion after a reset mid-refill): ignored.
- REQ entered while memory is still busy (i_readyM=0 at entry): hold i_readM=1 until i_readyM is seen high for at least one cycle, then apply the normal REQ rule. No deadlock.
- Counters wrap 0xFFFF→0x0000.

Decomposition:
- Package icache_pkg holds:
  - WORD_SIZE, LINE_WORDS, LINE_BITS(64);
  - field-width localparams;
  - the state encoding {IDLE, REQ, WAIT} as a 2-bit enum;
  - the line-word select function.
- One sub-module, icache_line_store: valid/tag/data arrays with an asynchronous-read lookup port, a synchronous line-write port and a flash-clear input for flush/reset.
- The top level holds the FSM, miss latch, counters and memory handshake.

Test Plan:
- Cold fetch: reset, then c_readC=1, c_address=0x0002 (line 0 holds 0x9023,0x0001,0xFFFF,0x0000).
  - Expect miss_count=1 and i_readM=1 with i_address=0x0000.
  - After i_input_readyM, expect c_readyC=1 and c_data=0xFFFF.
- Same-line hits: 0x0000, 0x0001, 0x0003 on consecutive cycles.
  - Expect c_readyC=1 each cycle with c_data 0x9023, 0x0001, 0x0000.
  - Expect hit_count +3 and no i_readM.
- Conflict eviction: fetch 0x0023 (index 0, tag 1).
  - Expect a miss, i_address=0x0020 and c_data=0x6000.
  - A refetch of 0x0000 misses again; miss_count increments.
- Flush in IDLE with line 0 valid: assert flush for 1 cycle, then fetch 0x0001.
  - Expect a miss and a refill.
- Flush during WAIT: the refill completes and the state returns to IDLE.
  - The next fetch of the same address misses again; no stale hit.
- Reset mid-WAIT: pull reset_n low asynchronously.
  - Immediately expect i_readM=0 and counters=0.
  - The stale i_input_readyM pulse is ignored.
  - The next fetch misses cleanly and returns the correct word.
